ap_com_lut_pipe: RTL and testbench
==================================

// Module: ap_com_lut_pipe
// PURPOSE
//   CH-channel array of K-input approximate compressors for the evolved
//   approximate Wallace multipliers. Each channel's truth table is runtime-programmable,
//   so the evolutionary loop can swap candidate compressors without resynthesis.
//   Tables are double-buffered: written to a shadow copy, then committed atomically.
//   Output is registered through a PIPE-deep valid/ready pipeline that stalls as a whole.
// PARAMETERS
//   K        2          inputs per compressor (1..4); table width TW = 2**K
//   CH       4          number of compressor channels (1..16)
//   PIPE     1          output register stages (1..3)
//   INIT_TT  {CH*TW{1'b0}} reset value of active and shadow tables; channel c = bits [c*TW +: TW]
// PORTS
//   clk        in   1                rising-edge clock
//   rst        in   1                asynchronous reset, active-high
//   in_valid   in   1                input sample valid
//   in_ready   out  1                pipeline can accept a sample
//   in_a       in   CH*K             channel c operands = in_a[c*K +: K]; MSB is the first operand
//   out_valid  out  1                out_y valid
//   out_ready  in   1                downstream accepts out_y
//   out_y      out  CH               channel c result
//   cfg_valid  in   1                table write request
//   cfg_ready  out  1                table write accepted when cfg_valid is also high
//   cfg_ch     in   $clog2(CH)+1     target channel
//   cfg_tt     in   TW               truth table; bit i = output for operand value i
//   cfg_commit in   1                copy the shadow tables to the active tables
//   cfg_err    out  1                one-cycle pulse: a write was accepted with cfg_ch >= CH
//   busy       out  1                high while the FSM is in COMMIT
// BEHAVIOUR
//   Reset: active = shadow = INIT_TT. out_valid=0, out_y=0, cfg_err=0, busy=0, FSM=IDLE.
//   Rst mid-operation flushes all pipeline stages. Any uncommitted shadow writes are lost.
//   Datapath: y[c] = active_tt[c][in_a[c*K +: K]], evaluated in the acceptance cycle.
//   The result leaves after exactly PIPE cycles when there is no stall.
//   Pipeline advance = out_ready | ~out_valid. in_ready = advance, a combinational function.
//   When advance=0, every stage holds, including out_y.
//   The pipeline contains no bubbles while advance stays high.
//   Each stage carries its own valid bit. A sample is accepted when in_valid & in_ready.
//   FSM states:
//     IDLE:   cfg_ready=1. An accepted write with cfg_ch<CH stores cfg_tt into shadow[cfg_ch].
//             An accepted write with cfg_ch>=CH is dropped and cfg_err pulses in the next cycle.
//             cfg_commit=1 moves the FSM to COMMIT.
//     COMMIT: exactly 1 cycle. cfg_ready=0, busy=1. active <= shadow. Return to IDLE.
//             cfg_commit is ignored while in COMMIT.
//   Write and commit in the same IDLE cycle: the write lands in shadow first and is included in the commit.
//   Tables take effect for samples accepted in the cycle after COMMIT.
//   Samples already in flight keep the results computed with the old tables.
//   The datapath never stalls for config. in_ready does not depend on the FSM.
//   K=2 with TW=4'b0000 reproduces a constant-0 compressor. TW=4'b1111 reproduces a constant-1 compressor.
// TESTING
//   1. Reset with INIT_TT=0, K=2, CH=4, PIPE=1. Stream in_a=8'hFF.
//      -> out_y=4'h0 one cycle after each accepted sample.
//   2. Write ch0 tt=4'b1000 (AND) and ch1 tt=4'b1110 (OR), then commit. Send in_a=8'b0000_1001.
//      -> out_y[0]=0, out_y[1]=1 after the commit has landed.
//   3. PIPE=3. Hold out_ready=0 for 5 cycles while in_valid=1.
//      -> exactly 3 samples accepted, in_ready=0 after that, out_y constant.
//      Release out_ready -> samples drain in order with no loss or duplicates.
//   4. Write ch2 and assert commit in the same cycle.
//      -> busy=1 and cfg_ready=0 for 1 cycle. The new ch2 table applies to the next accepted sample.
//   5. Write with cfg_ch=4 (CH=4) -> cfg_err pulses once, and all shadow and active tables are unchanged.
//   6. Assert rst while out_valid=1 and after an uncommitted shadow write.
//      -> out_valid=0 immediately, and a later commit restores INIT_TT behaviour.

Source files
------------

// File: rtl/ap_com_lut_if.sv
// Bundled sample, output and table-configuration signals for the approximate-compressor LUT pipeline.
// master drives samples and configuration; slave is the pipeline itself.
interface ap_com_lut_if #(
  parameter int unsigned K  = 2,
  parameter int unsigned CH = 4
);
  localparam int unsigned TW  = 2 ** K;
  localparam int unsigned CHW = $clog2(CH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CH*K-1:0]   in_a;
  logic              out_valid;
  logic              out_ready;
  logic [CH-1:0]     out_y;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CHW-1:0]    cfg_ch;
  logic [TW-1:0]     cfg_tt;
  logic              cfg_commit;
  logic              cfg_err;
  logic              busy;

  modport master (
    output in_valid, in_a, out_ready, cfg_valid, cfg_ch, cfg_tt, cfg_commit,
    input  in_ready, out_valid, out_y, cfg_ready, cfg_err, busy
  );

  modport slave (
    input  in_valid, in_a, out_ready, cfg_valid, cfg_ch, cfg_tt, cfg_commit,
    output in_ready, out_valid, out_y, cfg_ready, cfg_err, busy
  );
endinterface

// File: rtl/ap_com_lut_pipe.sv
// Array of CH runtime-programmable K-input approximate compressors with double-buffered
// truth tables and a PIPE-deep output pipeline that stalls as a whole.
module ap_com_lut_pipe #(
  parameter int unsigned K  = 2,
  parameter int unsigned CH = 4,
  parameter int unsigned PIPE = 1,
  parameter logic [CH*(2**K)-1:0] INIT_TT = '0
) (
  input  logic         clk,
  input  logic         rst,
  ap_com_lut_if.slave  bus
);

  localparam int unsigned TW   = 2 ** K;
  localparam int unsigned CHW  = $clog2(CH) + 1;
  localparam int unsigned LAST = PIPE - 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] COMMIT = 1'b1;

  typedef struct packed {
    logic          valid;
    logic [CH-1:0] y;
  } stage_t;

  logic [CH*TW-1:0] active_tt;
  logic [CH*TW-1:0] shadow_tt;
  logic [CH-1:0]    y_c;
  stage_t           stage_q [PIPE];
  logic             advance_c;

  logic [0:0] state_q, state_d;
  logic       wr_ok_c;
  logic       err_d;
  logic       commit_c;
  logic       busy_q;
  logic       cfg_ready_q;
  logic       cfg_err_q;

  // Per-channel table lookup on the operands presented this cycle
  for (genvar c = 0; c < CH; c++) begin : g_lut
    logic [TW-1:0] tt;
    logic [K-1:0]  sel;
    assign tt     = active_tt[c*TW +: TW];
    assign sel    = bus.in_a[c*K +: K];
    assign y_c[c] = tt[sel];
  end

  // Whole-pipeline advance: only a full, blocked output stage stalls everything
  assign advance_c    = bus.out_ready | ~stage_q[LAST].valid;
  assign bus.in_ready = advance_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE; i++) begin
        stage_q[i] <= '0;
      end
    end else if (advance_c) begin
      stage_q[0].valid <= bus.in_valid;
      stage_q[0].y     <= bus.in_valid ? y_c : '0;
      for (int unsigned i = 1; i < PIPE; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign bus.out_valid = stage_q[LAST].valid;
  assign bus.out_y     = stage_q[LAST].y;

  // Config FSM: next state and per-cycle table actions
  always_comb begin
    state_d  = state_q;
    wr_ok_c  = 1'b0;
    err_d    = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          if (bus.cfg_ch < CHW'(CH)) begin
            wr_ok_c = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (bus.cfg_commit) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        commit_c = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d == COMMIT);
      cfg_ready_q <= (state_d == IDLE);
      cfg_err_q   <= err_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cfg_err   = cfg_err_q;

  // Shadow takes writes only in IDLE and active copies it only in COMMIT, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_tt <= INIT_TT;
      active_tt <= INIT_TT;
    end else begin
      if (wr_ok_c) begin
        for (int unsigned c = 0; c < CH; c++) begin
          if (bus.cfg_ch == CHW'(c)) begin
            shadow_tt[c*TW +: TW] <= bus.cfg_tt;
          end
        end
      end
      if (commit_c) begin
        active_tt <= shadow_tt;
      end
    end
  end

endmodule

// File: tb/tb_ap_com_lut_pipe.sv
// Directed bench for ap_com_lut_pipe: a PIPE=1 instance with zero reset tables and a
// PIPE=3 instance whose reset tables pass each channel's low operand bit through.
module tb_ap_com_lut_pipe;
  localparam int unsigned K  = 2;
  localparam int unsigned CH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ap_com_lut_if #(.K(K), .CH(CH)) ifa ();
  ap_com_lut_if #(.K(K), .CH(CH)) ifb ();

  ap_com_lut_pipe #(.K(K), .CH(CH), .PIPE(1), .INIT_TT(16'h0000)) u_dut1 (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  ap_com_lut_pipe #(.K(K), .CH(CH), .PIPE(3), .INIT_TT(16'hAAAA)) u_dut3 (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  // With table 4'b1010 on every channel, y[c] = in_a[2c]; place v's bits there
  function automatic logic [7:0] enc(input logic [3:0] v);
    logic [7:0] a;
    a = '0;
    for (int c = 0; c < 4; c++) a[2*c] = v[c];
    return a;
  endfunction

  task automatic idle_inputs();
    ifa.in_valid = 1'b0; ifa.in_a = '0; ifa.out_ready = 1'b1;
    ifa.cfg_valid = 1'b0; ifa.cfg_ch = 3'd0; ifa.cfg_tt = 4'h0; ifa.cfg_commit = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_a = '0; ifb.out_ready = 1'b1;
    ifb.cfg_valid = 1'b0; ifb.cfg_ch = 3'd0; ifb.cfg_tt = 4'h0; ifb.cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ifa.out_valid); end
    checks++; if (ifa.out_y !== 4'h0) begin errors++; $display("FAIL reset_out_y: got %h expected 0", ifa.out_y); end
    checks++; if (ifa.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", ifa.cfg_err); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ifa.busy); end
    checks++; if (ifa.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 1", ifa.cfg_ready); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ifa.in_ready); end
    checks++; if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL reset_p3_out_valid: got %b expected 0", ifb.out_valid); end
    checks++; if (ifb.busy !== 1'b0) begin errors++; $display("FAIL reset_p3_busy: got %b expected 0", ifb.busy); end
  endtask

  task automatic test_stream_zero();
    ifa.in_valid = 1'b1;
    ifa.in_a     = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, ifa.out_valid); end
      checks++; if (ifa.out_y !== 4'h0) begin errors++; $display("FAIL stream_y[%0d]: got %h expected 0", i, ifa.out_y); end
    end
    ifa.in_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b expected 0", ifa.out_valid); end
  endtask

  task automatic test_and_or();
    @(negedge clk);
    ifa.cfg_valid = 1'b1; ifa.cfg_ch = 3'd0; ifa.cfg_tt = 4'b1000;
    @(negedge clk);
    ifa.cfg_ch = 3'd1; ifa.cfg_tt = 4'b1110;
    @(negedge clk);
    ifa.cfg_valid = 1'b0; ifa.cfg_commit = 1'b1;
    @(negedge clk); #1;
    checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL andor_busy: got %b expected 1", ifa.busy); end
    checks++; if (ifa.cfg_ready !== 1'b0) begin errors++; $display("FAIL andor_cfg_ready: got %b expected 0", ifa.cfg_ready); end
    ifa.cfg_commit = 1'b0;
    ifa.in_valid   = 1'b1;
    ifa.in_a       = 8'b0000_1001;
    @(negedge clk); #1;
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL andor_busy_after: got %b expected 0", ifa.busy); end
    checks++; if (ifa.cfg_ready !== 1'b1) begin errors++; $display("FAIL andor_cfg_ready_after: got %b expected 1", ifa.cfg_ready); end
    checks++; if (ifa.out_y !== 4'b0000) begin errors++; $display("FAIL andor_old_table_y: got %b expected 0000", ifa.out_y); end
    @(negedge clk); #1;
    checks++; if (ifa.out_y !== 4'b0010) begin errors++; $display("FAIL andor_new_table_y: got %b expected 0010", ifa.out_y); end
    ifa.in_valid = 1'b0;
  endtask

  task automatic test_same_cycle_commit();
    @(negedge clk);
    ifa.cfg_valid = 1'b1; ifa.cfg_ch = 3'd2; ifa.cfg_tt = 4'b1111; ifa.cfg_commit = 1'b1;
    @(negedge clk); #1;
    checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL same_busy: got %b expected 1", ifa.busy); end
    checks++; if (ifa.cfg_ready !== 1'b0) begin errors++; $display("FAIL same_cfg_ready: got %b expected 0", ifa.cfg_ready); end
    ifa.cfg_valid = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_a      = 8'h00;
    @(negedge clk); #1;
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL same_commit_ignored_busy: got %b expected 0", ifa.busy); end
    checks++; if (ifa.cfg_ready !== 1'b1) begin errors++; $display("FAIL same_cfg_ready_after: got %b expected 1", ifa.cfg_ready); end
    checks++; if (ifa.out_y !== 4'b0000) begin errors++; $display("FAIL same_old_table_y: got %b expected 0000", ifa.out_y); end
    ifa.cfg_commit = 1'b0;
    @(negedge clk); #1;
    checks++; if (ifa.out_y !== 4'b0100) begin errors++; $display("FAIL same_new_table_y: got %b expected 0100", ifa.out_y); end
    ifa.in_valid = 1'b0;
  endtask

  task automatic test_cfg_err();
    @(negedge clk);
    ifa.cfg_valid = 1'b1; ifa.cfg_ch = 3'd4; ifa.cfg_tt = 4'b1111;
    @(negedge clk); #1;
    checks++; if (ifa.cfg_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b expected 1", ifa.cfg_err); end
    ifa.cfg_valid = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_a      = 8'h00;
    @(negedge clk); #1;
    checks++; if (ifa.cfg_err !== 1'b0) begin errors++; $display("FAIL err_single: got %b expected 0", ifa.cfg_err); end
    checks++; if (ifa.out_y !== 4'b0100) begin errors++; $display("FAIL err_active_kept: got %b expected 0100", ifa.out_y); end
    ifa.in_valid   = 1'b0;
    ifa.cfg_commit = 1'b1;
    @(negedge clk); #1;
    checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL err_commit_busy: got %b expected 1", ifa.busy); end
    ifa.cfg_commit = 1'b0;
    @(negedge clk);
    ifa.in_valid = 1'b1;
    ifa.in_a     = 8'h00;
    @(negedge clk); #1;
    checks++; if (ifa.out_y !== 4'b0100) begin errors++; $display("FAIL err_shadow_kept: got %b expected 0100", ifa.out_y); end
    ifa.in_valid = 1'b0;
  endtask

  task automatic test_stall_drain();
    logic [3:0] expq[$];
    int acc = 0;
    int got = 0;
    int next_v = 1;
    int guard = 0;
    @(negedge clk);
    ifb.out_ready = 1'b0;
    ifb.in_valid  = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      ifb.in_a = enc(4'(next_v));
      #1;
      if (cyc >= 3) begin
        checks++; if (ifb.out_y !== 4'd1) begin errors++; $display("FAIL stall_hold_y[%0d]: got %h expected 1", cyc, ifb.out_y); end
      end
      if (ifb.in_ready) begin
        expq.push_back(4'(next_v));
        acc++;
        next_v++;
      end
      @(negedge clk);
    end
    #1;
    checks++; if (acc !== 3) begin errors++; $display("FAIL stall_accepted: got %0d expected 3", acc); end
    checks++; if (ifb.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", ifb.in_ready); end
    checks++; if (ifb.out_y !== 4'd1) begin errors++; $display("FAIL stall_out_y: got %h expected 1", ifb.out_y); end
    ifb.out_ready = 1'b1;
    while ((next_v <= 6 || expq.size() > 0) && guard < 40) begin
      ifb.in_valid = (next_v <= 6);
      ifb.in_a     = enc(4'(next_v));
      #1;
      if (ifb.out_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL drain_extra: got %h expected none", ifb.out_y);
        end else if (ifb.out_y !== expq[0]) begin
          errors++; $display("FAIL drain_order: got %h expected %h", ifb.out_y, expq[0]);
        end
        if (expq.size() > 0) void'(expq.pop_front());
        got++;
      end
      if (ifb.in_valid && ifb.in_ready) begin
        expq.push_back(4'(next_v));
        next_v++;
      end
      @(negedge clk);
      guard++;
    end
    ifb.in_valid = 1'b0;
    #1;
    checks++; if (guard >= 40) begin errors++; $display("FAIL drain_timeout: got %0d cycles expected under 40", guard); end
    checks++; if (got !== 6) begin errors++; $display("FAIL drain_count: got %0d expected 6", got); end
    checks++; if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", ifb.out_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ifa.cfg_valid = 1'b1; ifa.cfg_ch = 3'd3; ifa.cfg_tt = 4'b1111;
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_a      = 8'h00;
    @(negedge clk);
    ifa.cfg_valid = 1'b0;
    ifa.in_valid  = 1'b0;
    #1;
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", ifa.out_valid); end
    checks++; if (ifa.out_y !== 4'b0100) begin errors++; $display("FAIL rstmid_pre_y: got %b expected 0100", ifa.out_y); end
    rst = 1'b1;
    #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flush_valid: got %b expected 0", ifa.out_valid); end
    checks++; if (ifa.out_y !== 4'h0) begin errors++; $display("FAIL rstmid_flush_y: got %h expected 0", ifa.out_y); end
    @(negedge clk);
    rst = 1'b0;
    ifa.out_ready  = 1'b1;
    ifa.cfg_commit = 1'b1;
    @(negedge clk);
    ifa.cfg_commit = 1'b0;
    ifa.in_valid   = 1'b1;
    ifa.in_a       = 8'hFF;
    #1;
    checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL rstmid_commit_busy: got %b expected 1", ifa.busy); end
    @(negedge clk); #1;
    checks++; if (ifa.out_y !== 4'h0) begin errors++; $display("FAIL rstmid_active_init: got %b expected 0000", ifa.out_y); end
    @(negedge clk); #1;
    checks++; if (ifa.out_y !== 4'h0) begin errors++; $display("FAIL rstmid_shadow_init: got %b expected 0000", ifa.out_y); end
    ifa.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream_zero();
    test_and_or();
    test_same_cycle_commit();
    test_cfg_err();
    test_stall_drain();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
